// File: rtl/ttt_pkg.sv
// Shared encodings and win-line table for the tic-tac-toe board controller.
// Cells are numbered row-major: 0 = A (top-left) ... 8 = I (bottom-right).
package ttt_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    typedef enum logic [1:0] {
        GS_PLAY = 2'b00,
        GS_WIN  = 2'b01,
        GS_DRAW = 2'b10
    } game_state_e;

    typedef enum logic [1:0] {
        WN_NONE = 2'b00,
        WN_ONE  = 2'b01,
        WN_TWO  = 2'b10
    } winner_e;

    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [3:0] cell_count(input logic [NUM_CELLS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One board switch: 2-FF synchroniser, stability counter, debounced level,
// and a registered single-cycle pulse on the debounced 0->1 transition.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only advances while the synced level disagrees with the
    // accepted level; any return to agreement restarts the window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/board_controller.sv
// Tic-tac-toe board controller: conditions switches, validates moves, runs the game FSM.
// Optional SCORE_COUNT_EN adds saturating per-player win counters.
module board_controller
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] sw,
    input  logic       new_game,
    output logic [8:0] occupied,
    output logic [8:0] owner,
    output logic       move_valid,
    output logic       move_illegal,
    output logic [1:0] game_state,
`ifdef SCORE_COUNT_EN
    output logic [3:0] score_one,
    output logic [3:0] score_two,
`endif
    output logic [1:0] winner
);

    logic [8:0]  rise;
    logic [3:0]  rise_cnt;
    logic        mover;
    logic        line_win;
    logic        line_owner;
    logic        board_full;
    logic        game_over;

    logic [8:0]  occ_q;
    logic [8:0]  occ_d;
    logic [8:0]  owner_q;
    logic [8:0]  owner_d;
    logic        valid_q;
    logic        valid_d;
    logic        illegal_q;
    logic        illegal_d;
    game_state_e state_q;
    game_state_e state_d;
    winner_e     winner_q;
    winner_e     winner_d;

    for (genvar g = 0; g < NUM_CELLS; g++) begin : g_sw
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .sw_in(sw[g]),
            .rise (rise[g])
        );
    end

    always_comb begin
        line_win   = 1'b0;
        line_owner = 1'b0;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (!line_win
                && occ_q[WIN_LINES[l][0]]
                && occ_q[WIN_LINES[l][1]]
                && occ_q[WIN_LINES[l][2]]
                && (owner_q[WIN_LINES[l][0]] == owner_q[WIN_LINES[l][1]])
                && (owner_q[WIN_LINES[l][1]] == owner_q[WIN_LINES[l][2]])) begin
                line_win   = 1'b1;
                line_owner = owner_q[WIN_LINES[l][0]];
            end
        end
    end

    // Odd number of taken cells means player two is to move.
    assign mover      = ^occ_q;
    assign rise_cnt   = cell_count(rise);
    assign board_full = &occ_q;
    // A decided board still reads PLAY for one cycle; block moves then too.
    assign game_over  = (state_q != GS_PLAY) | line_win | board_full;

    always_comb begin
        occ_d     = occ_q;
        owner_d   = owner_q;
        state_d   = state_q;
        winner_d  = winner_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        if (new_game) begin
            occ_d    = '0;
            owner_d  = '0;
            state_d  = GS_PLAY;
            winner_d = WN_NONE;
        end else begin
            if (|rise) begin
                if (game_over || (rise_cnt > 4'd1) || |(rise & occ_q)) begin
                    illegal_d = 1'b1;
                end else begin
                    occ_d   = occ_q | rise;
                    owner_d = mover ? (owner_q | rise) : (owner_q & ~rise);
                    valid_d = 1'b1;
                end
            end
            case (state_q)
                GS_PLAY: begin
                    if (line_win) begin
                        state_d  = GS_WIN;
                        winner_d = line_owner ? WN_TWO : WN_ONE;
                    end else if (board_full) begin
                        state_d = GS_DRAW;
                    end
                end
                GS_WIN, GS_DRAW: begin
                    state_d = state_q;
                end
                default: begin
                    state_d  = GS_PLAY;
                    winner_d = WN_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q     <= '0;
            owner_q   <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            state_q   <= GS_PLAY;
            winner_q  <= WN_NONE;
        end else begin
            occ_q     <= occ_d;
            owner_q   <= owner_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            state_q   <= state_d;
            winner_q  <= winner_d;
        end
    end

`ifdef SCORE_COUNT_EN
    logic [3:0] score_one_q;
    logic [3:0] score_one_d;
    logic [3:0] score_two_q;
    logic [3:0] score_two_d;

    always_comb begin
        score_one_d = score_one_q;
        score_two_d = score_two_q;
        if ((state_q == GS_PLAY) && (state_d == GS_WIN)) begin
            if ((winner_d == WN_ONE) && (score_one_q != 4'hF)) begin
                score_one_d = score_one_q + 4'd1;
            end
            if ((winner_d == WN_TWO) && (score_two_q != 4'hF)) begin
                score_two_d = score_two_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_one_q <= '0;
            score_two_q <= '0;
        end else begin
            score_one_q <= score_one_d;
            score_two_q <= score_two_d;
        end
    end

    assign score_one = score_one_q;
    assign score_two = score_two_q;
`endif

    assign occupied     = occ_q;
    assign owner        = owner_q;
    assign move_valid   = valid_q;
    assign move_illegal = illegal_q;
    assign game_state   = state_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_board_controller.sv
// Bench for board_controller with a short debounce window.
// Move vectors come from a table; pulses are matched against an expected queue.
module tb_board_controller;

    logic       clk;
    logic       rst;
    logic [8:0] sw;
    logic       new_game;
    logic [8:0] occupied;
    logic [8:0] owner;
    logic       move_valid;
    logic       move_illegal;
    logic [1:0] game_state;
    logic [1:0] winner;
`ifdef SCORE_COUNT_EN
    logic [3:0] score_one;
    logic [3:0] score_two;
`endif

    board_controller #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .new_game    (new_game),
        .occupied    (occupied),
        .owner       (owner),
        .move_valid  (move_valid),
        .move_illegal(move_illegal),
        .game_state  (game_state),
`ifdef SCORE_COUNT_EN
        .score_one   (score_one),
        .score_two   (score_two),
`endif
        .winner      (winner)
    );

    typedef struct {
        logic [8:0] sw;
        logic [1:0] pulse;
        logic [8:0] occ;
        logic [8:0] own;
        logic [1:0] gs;
        logic [1:0] win;
    } vec_t;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_ILL  = 2'b01;
    localparam logic [1:0] P_VAL  = 2'b10;

    int         n_total = 0;
    int         n_pass  = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_p;
    vec_t       tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act,
                         input logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && (move_valid || move_illegal)) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: got valid=%0b illegal=%0b, required none",
                         move_valid, move_illegal);
            end else begin
                exp_p = exp_q.pop_front();
                check("pulse", 9'({move_valid, move_illegal}), 9'(exp_p));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit, required completion");
        $fatal(1);
    end

    function automatic vec_t mk(logic [8:0] s, logic [1:0] p, logic [8:0] o,
                                logic [8:0] w, logic [1:0] g, logic [1:0] wn);
        vec_t v;
        v.sw = s; v.pulse = p; v.occ = o; v.own = w; v.gs = g; v.win = wn;
        return v;
    endfunction

    task automatic apply(input int idx);
        vec_t v;
        v = tbl[idx];
        if (v.pulse != P_NONE) exp_q.push_back(v.pulse);
        @(posedge clk); #1 sw = v.sw;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d_occ", idx), occupied, v.occ);
        check($sformatf("v%0d_own", idx), owner & occupied, v.own);
        check($sformatf("v%0d_gs", idx), 9'(game_state), 9'(v.gs));
        check($sformatf("v%0d_win", idx), 9'(winner), 9'(v.win));
        check($sformatf("v%0d_pending", idx), 9'(exp_q.size()), 9'h000);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(i);
    endtask

    task automatic clear_board(input string tag);
        @(posedge clk); #1 sw = 9'h000;
        repeat (10) @(posedge clk);
        #1 new_game = 1'b1;
        @(posedge clk); #1 new_game = 1'b0;
        @(negedge clk);
        check({tag, "_occ"}, occupied, 9'h000);
        check({tag, "_gs"}, 9'(game_state), 9'h000);
        check({tag, "_win"}, 9'(winner), 9'h000);
    endtask

    initial begin
        // game 1: first move, then illegal patterns
        tbl.push_back(mk(9'h001, P_VAL,  9'h001, 9'h000, 2'b00, 2'b00)); // 0
        tbl.push_back(mk(9'h055, P_ILL,  9'h011, 9'h010, 2'b00, 2'b00)); // 1
        tbl.push_back(mk(9'h054, P_NONE, 9'h011, 9'h010, 2'b00, 2'b00)); // 2
        tbl.push_back(mk(9'h055, P_ILL,  9'h011, 9'h010, 2'b00, 2'b00)); // 3
        // win for player one: A D B E C, then I rejected
        tbl.push_back(mk(9'h001, P_VAL,  9'h001, 9'h000, 2'b00, 2'b00)); // 4
        tbl.push_back(mk(9'h009, P_VAL,  9'h009, 9'h008, 2'b00, 2'b00)); // 5
        tbl.push_back(mk(9'h00B, P_VAL,  9'h00B, 9'h008, 2'b00, 2'b00)); // 6
        tbl.push_back(mk(9'h01B, P_VAL,  9'h01B, 9'h018, 2'b00, 2'b00)); // 7
        tbl.push_back(mk(9'h01F, P_VAL,  9'h01F, 9'h018, 2'b01, 2'b01)); // 8
        tbl.push_back(mk(9'h11F, P_ILL,  9'h01F, 9'h018, 2'b01, 2'b01)); // 9
        // draw: 0 1 2 4 3 5 7 6 8
        tbl.push_back(mk(9'h001, P_VAL,  9'h001, 9'h000, 2'b00, 2'b00)); // 10
        tbl.push_back(mk(9'h003, P_VAL,  9'h003, 9'h002, 2'b00, 2'b00)); // 11
        tbl.push_back(mk(9'h007, P_VAL,  9'h007, 9'h002, 2'b00, 2'b00)); // 12
        tbl.push_back(mk(9'h017, P_VAL,  9'h017, 9'h012, 2'b00, 2'b00)); // 13
        tbl.push_back(mk(9'h01F, P_VAL,  9'h01F, 9'h012, 2'b00, 2'b00)); // 14
        tbl.push_back(mk(9'h03F, P_VAL,  9'h03F, 9'h032, 2'b00, 2'b00)); // 15
        tbl.push_back(mk(9'h0BF, P_VAL,  9'h0BF, 9'h032, 2'b00, 2'b00)); // 16
        tbl.push_back(mk(9'h0FF, P_VAL,  9'h0FF, 9'h072, 2'b00, 2'b00)); // 17
        tbl.push_back(mk(9'h1FF, P_VAL,  9'h1FF, 9'h072, 2'b10, 2'b00)); // 18
        // after a discarded commit, cell B still usable
        tbl.push_back(mk(9'h003, P_VAL,  9'h002, 9'h000, 2'b00, 2'b00)); // 19

        rst = 1'b1; sw = 9'h000; new_game = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_occ", occupied, 9'h000);
        check("rst_own", owner, 9'h000);
        check("rst_gs", 9'(game_state), 9'h000);
        check("rst_win", 9'(winner), 9'h000);
        check("rst_pulses", 9'({move_valid, move_illegal}), 9'h000);

        run_range(0, 0);

        // sw[4] bounces every 2 cycles, then holds high
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            sw[4] = (k % 2 == 0);
            repeat (2) @(posedge clk);
            #1;
        end
        sw[4] = 1'b1;
        exp_q.push_back(P_VAL);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bounce_early_occ", occupied, 9'h001);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bounce_occ", occupied, 9'h011);
        check("bounce_own", owner & occupied, 9'h010);
        check("bounce_pending", 9'(exp_q.size()), 9'h000);

        run_range(1, 3);
        clear_board("ng1");
        run_range(4, 9);
        clear_board("ng2");
        run_range(10, 18);
        clear_board("ng3");

        // new_game lands on the same edge as a pending commit
        @(posedge clk); #1 sw = 9'h001;
        repeat (6) @(posedge clk);
        #1 new_game = 1'b1;
        @(posedge clk); #1 new_game = 1'b0;
        check("ngc_valid", 9'(move_valid), 9'h000);
        check("ngc_occ", occupied, 9'h000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ngc_late_occ", occupied, 9'h000);
        run_range(19, 19);

        // asynchronous reset mid-game and mid-debounce
        @(posedge clk); #1 sw = 9'h007;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("amid_occ", occupied, 9'h000);
        check("amid_own", owner, 9'h000);
        check("amid_gs", 9'(game_state), 9'h000);
        sw = 9'h000;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("arst_occ", occupied, 9'h000);
        check("arst_pending", 9'(exp_q.size()), 9'h000);

        run_range(4, 9);
        clear_board("ng4");
        run_range(4, 7);

        // fifth move: exact commit and win timing
        exp_q.push_back(P_VAL);
        @(posedge clk); #1 sw = 9'h01F;
        repeat (7) @(posedge clk);
        #1;
        check("w5_valid", 9'(move_valid), 9'h001);
        check("w5_gs_play", 9'(game_state), 9'h000);
        check("w5_occ", occupied, 9'h01F);
        @(posedge clk); #1;
        check("w5_gs_win", 9'(game_state), 9'h001);
        check("w5_winner", 9'(winner), 9'h001);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("w5_pending", 9'(exp_q.size()), 9'h000);
`ifdef SCORE_COUNT_EN
        check("score_one", 9'(score_one), 9'h002);
        check("score_two", 9'(score_two), 9'h000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
